// File: rtl/fifo_feeder_if.sv
// Handshake bundle between the memory-side loader, the feeder and its delay-buffer fifo.
interface fifo_feeder_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 64
);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            start;
  logic            abort;
  logic            fifo_en;
  logic [BITS-1:0] fifo_d;
  logic [LW-1:0]   level;
  logic            loaded;
  logic            out_valid;
  logic            done;

  modport master (
    output in_valid, in_data, start, abort,
    input  in_ready, fifo_en, fifo_d, level, loaded, out_valid, done
  );

  modport slave (
    input  in_valid, in_data, start, abort,
    output in_ready, fifo_en, fifo_d, level, loaded, out_valid, done
  );
endinterface

// File: rtl/fifo_feeder.sv
// Loads DEPTH words into a shift-on-en delay fifo, then streams them out on start,
// flushing zeros in behind so the fifo is empty once the stream completes.
module fifo_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 64
) (
  input logic          clk,
  input logic          rst_n,
  fifo_feeder_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_FULL   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            in_ready_c;
  logic            fifo_en_c;
  logic [BITS-1:0] fifo_d_c;
  logic [CW-1:0]   level_c;
  logic            loaded_c;
  logic            out_valid_c;
  logic            last_c;

  assign last_c = (cnt_q == CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    in_ready_c  = 1'b0;
    fifo_en_c   = 1'b0;
    fifo_d_c    = '0;
    level_c     = '0;
    loaded_c    = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      S_LOAD: begin
        // in_ready is gated by rst_n so nothing is offered while the fifo is held in reset
        in_ready_c = rst_n & ~bus.abort;
        level_c    = cnt_q;
        if (bus.in_valid && in_ready_c) begin
          fifo_en_c = 1'b1;
          fifo_d_c  = bus.in_data;
          cnt_d     = cnt_q + CW'(1);
          if (last_c) state_d = S_FULL;
        end
      end
      S_FULL: begin
        loaded_c = 1'b1;
        level_c  = cnt_q;
        if (bus.start) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        fifo_en_c   = 1'b1;
        out_valid_c = 1'b1;
        cnt_d       = cnt_q + CW'(1);
        if (last_c) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything: freeze the fifo and restart the load.
    if (bus.abort) begin
      in_ready_c = 1'b0;
      fifo_en_c  = 1'b0;
      fifo_d_c   = '0;
      state_d    = S_LOAD;
      cnt_d      = '0;
      done_d     = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.fifo_en   = fifo_en_c;
  assign bus.fifo_d    = fifo_d_c;
  assign bus.level     = level_c;
  assign bus.loaded    = loaded_c;
  assign bus.out_valid = out_valid_c;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fifo_feeder.sv
// Directed bench for fifo_feeder with a behavioural shift-on-en fifo attached.
module tb_fifo_feeder;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BITS  = 64;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fifo_feeder_if #(.DEPTH(DEPTH), .BITS(BITS)) bus ();

  fifo_feeder #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Attached fifo: shifts d in at the tail on en, q is the oldest entry.
  logic [BITS-1:0] mem [DEPTH];
  logic [BITS-1:0] q;
  assign q = mem[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.fifo_en) begin
      mem[0] <= bus.fifo_d;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle before checking.
  task automatic drive(input logic v, input logic [63:0] d, input logic s, input logic a);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = s;
    bus.abort    = a;
    #1;
  endtask

  task automatic load_seq(input logic [63:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, base + 64'(i), 1'b0, 1'b0);
      chk("load_en",    64'(bus.fifo_en), 64'd1);
      chk("load_d",     bus.fifo_d, base + 64'(i));
      chk("load_level", 64'(bus.level), 64'(i));
      chk("load_rdy",   64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("full_loaded", 64'(bus.loaded), 64'd1);
    chk("full_level",  64'(bus.level), 64'(DEPTH));
    chk("full_rdy",    64'(bus.in_ready), 64'd0);
    chk("full_en",     64'(bus.fifo_en), 64'd0);
    chk("full_q",      q, base);
  endtask

  // Start from FULL, then expect base+k on q for DEPTH cycles; start held high at cycle sk.
  task automatic stream_seq(input logic [63:0] base, input int sk);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    chk("start_loaded", 64'(bus.loaded), 64'd1);
    chk("start_ov",     64'(bus.out_valid), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 64'h0, (k == sk), 1'b0);
      chk("str_ov",    64'(bus.out_valid), 64'd1);
      chk("str_q",     q, base + 64'(k));
      chk("str_en",    64'(bus.fifo_en), 64'd1);
      chk("str_d",     bus.fifo_d, 64'h0);
      chk("str_level", 64'(bus.level), 64'd0);
      chk("str_done",  64'(bus.done), 64'd0);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("done_ov",    64'(bus.out_valid), 64'd0);
    chk("done_q",     q, 64'h0);
    chk("done_rdy",   64'(bus.in_ready), 64'd1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("done_clr",   64'(bus.done), 64'd0);
    chk("idle_level", 64'(bus.level), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h55;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    #3;
    // reset values, in_ready low even with in_valid high
    chk("rst_rdy",    64'(bus.in_ready), 64'd0);
    chk("rst_en",     64'(bus.fifo_en), 64'd0);
    chk("rst_d",      bus.fifo_d, 64'h0);
    chk("rst_level",  64'(bus.level), 64'd0);
    chk("rst_loaded", 64'(bus.loaded), 64'd0);
    chk("rst_ov",     64'(bus.out_valid), 64'd0);
    chk("rst_done",   64'(bus.done), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1/2: plain load of 1..8, stream back
    load_seq(64'd1);
    stream_seq(64'd1, -1);

    // 3: in_valid toggling, only accepted beats shift
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (i % 2 == 0) begin
        drive(1'b1, 64'hA0 + 64'(i / 2), 1'b0, 1'b0);
        chk("tog_en", 64'(bus.fifo_en), 64'd1);
        chk("tog_d",  bus.fifo_d, 64'hA0 + 64'(i / 2));
      end else begin
        drive(1'b0, 64'hDEAD, 1'b0, 1'b0);
        chk("tog_gap_en", 64'(bus.fifo_en), 64'd0);
        chk("tog_gap_d",  bus.fifo_d, 64'h0);
      end
      chk("tog_level", 64'(bus.level), 64'((i + 1) / 2));
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("tog_loaded", 64'(bus.loaded), 64'd1);
    chk("tog_q",      q, 64'hA0);
    stream_seq(64'hA0, -1);

    // 4: abort after 5 beats, then full reload hides old data
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
      chk("pre_abort_en", 64'(bus.fifo_en), 64'd1);
    end
    drive(1'b1, 64'hC5, 1'b0, 1'b1);
    chk("abort_rdy",   64'(bus.in_ready), 64'd0);
    chk("abort_en",    64'(bus.fifo_en), 64'd0);
    chk("abort_level", 64'(bus.level), 64'd5);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("post_abort_level", 64'(bus.level), 64'd0);
    chk("post_abort_rdy",   64'(bus.in_ready), 64'd1);
    load_seq(64'hB0);
    stream_seq(64'hB0, -1);

    // 5: start in LOAD and in STREAM ignored; start+abort in FULL returns to LOAD
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'hD0 + 64'(i), (i == 3), 1'b0);
      chk("ld_start_en",    64'(bus.fifo_en), 64'd1);
      chk("ld_start_level", 64'(bus.level), 64'(i));
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("ld_start_loaded", 64'(bus.loaded), 64'd1);
    stream_seq(64'hD0, 2);
    load_seq(64'hE0);
    drive(1'b0, 64'h0, 1'b1, 1'b1);
    chk("sa_en",     64'(bus.fifo_en), 64'd0);
    chk("sa_loaded", 64'(bus.loaded), 64'd1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("sa_loaded2", 64'(bus.loaded), 64'd0);
    chk("sa_ov",      64'(bus.out_valid), 64'd0);
    chk("sa_level",   64'(bus.level), 64'd0);
    chk("sa_rdy",     64'(bus.in_ready), 64'd1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("sa_ov2",     64'(bus.out_valid), 64'd0);
    chk("sa_en2",     64'(bus.fifo_en), 64'd0);

    // 6: reset during stream cycle k=4, then normal operation
    load_seq(64'hF0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      chk("pre_rst_q", q, 64'hF0 + 64'(k));
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",   64'(bus.out_valid), 64'd0);
    chk("mid_rst_en",   64'(bus.fifo_en), 64'd0);
    chk("mid_rst_rdy",  64'(bus.in_ready), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_q",    q, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_done", 64'(bus.done), 64'd0);
    chk("post_rst_rdy",  64'(bus.in_ready), 64'd1);
    load_seq(64'd1);
    stream_seq(64'd1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "bench timeout");
  end
endmodule
